// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end for the multicycle CPU.
// Holds the program counter and the instruction register, runs the
// instruction-memory request/acknowledge handshake and selects the next pc
// from the controller's PC write controls.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for fetch_start; the only state in which pc may change
// REQ   | imem_req high at the current pc until imem_ack
// DONE  | one-cycle fetch_done pulse, then back to IDLE
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic              IRWrite,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic              BEQ,
    input  logic              zero,
    input  logic [1:0]        PCSrc,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] reg_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [5:0]        opcode,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic [31:0]       fetch_count,
    output logic              pc_update_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              pcw;
    logic              ack_take;
    logic [ADDR_W-1:0] pc_nxt;

    // Branch is taken when the zero flag matches the requested sense.
    assign pcw      = PCWrite | (PCWriteCond & (BEQ ? zero : ~zero));
    assign ack_take = (state == REQ) && imem_ack;

    // Next-pc candidate selected by PCSrc; only loaded when pcw in IDLE.
    always_comb begin
        pc_nxt = pc;
        case (PCSrc)
            2'd0:    pc_nxt = pc + ADDR_W'(PC_INC);
            2'd1:    pc_nxt = branch_target;
            2'd2:    pc_nxt = {pc[ADDR_W-1:26], ir[25:0]};
            default: pc_nxt = reg_target;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic; the memory wait in REQ is unbounded.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_start) state_nxt = REQ;
            REQ:     if (imem_ack)    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; the request address is simply the pc, which cannot move
    // outside IDLE, so it stays stable for the whole request.
    always_comb begin
        imem_req   = (state == REQ);
        fetch_done = (state == DONE);
        fetch_busy = (state == REQ) || (state == DONE);
    end

    assign imem_addr = pc;
    assign opcode    = ir[31:26];

    // Program counter: loads in IDLE only; a load while busy is flagged instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            pc_update_err <= 1'b0;
        end else if (pcw) begin
            if (state == IDLE) pc            <= pc_nxt;
            else               pc_update_err <= 1'b1;
        end
    end

    // Instruction register and completed-fetch counter, both advanced on the ack edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir          <= '0;
            fetch_count <= '0;
        end else if (ack_take) begin
            if (IRWrite) ir <= imem_rdata;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed cases from the test plan,
// then a randomized mix of pc updates, fetches and stray acks compared with
// a transaction-level reference model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start, IRWrite, PCWrite, PCWriteCond, BEQ, zero;
    logic [1:0]  PCSrc;
    logic [31:0] branch_target, reg_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc, ir;
    logic [5:0]  opcode;
    logic        fetch_busy, fetch_done;
    logic [31:0] fetch_count;
    logic        pc_update_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc, m_ir, m_cnt;
    logic        m_err;

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .PC_INC(1)) dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BEQ(BEQ), .zero(zero),
        .PCSrc(PCSrc), .branch_target(branch_target), .reg_target(reg_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .ir(ir), .opcode(opcode),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done),
        .fetch_count(fetch_count), .pc_update_err(pc_update_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_ctl;
        PCWrite = 0; PCWriteCond = 0; BEQ = 0; zero = 0; PCSrc = 0;
    endtask

    task automatic model_reset;
        m_pc = 32'h0; m_ir = 32'h0; m_cnt = 32'h0; m_err = 1'b0;
    endtask

    // Where the pc goes if the currently driven controls are honoured.
    function automatic logic [31:0] model_target(input logic [1:0] src);
        if (src == 2'd0)      return m_pc + 32'd1;
        else if (src == 2'd1) return branch_target;
        else if (src == 2'd2) return (m_pc & 32'hFC00_0000) | (m_ir & 32'h03FF_FFFF);
        else                  return reg_target;
    endfunction

    function automatic bit model_taken(input logic pw, input logic pwc, input logic beq, input logic z);
        if (pw) return 1'b1;
        if (!pwc) return 1'b0;
        return beq ? (z == 1'b1) : (z == 1'b0);
    endfunction

    task automatic pc_update(input logic pw, input logic pwc, input logic beq, input logic z,
                             input logic [1:0] src, input logic [31:0] bt, input logic [31:0] rt);
        PCWrite = pw; PCWriteCond = pwc; BEQ = beq; zero = z; PCSrc = src;
        branch_target = bt; reg_target = rt;
        if (model_taken(pw, pwc, beq, z)) m_pc = model_target(src);
        tick;
        clear_ctl;
        check("pc_update", pc, m_pc);
        check("idle_req", {31'b0, imem_req}, 32'd0);
    endtask

    // One complete fetch; every cycle of the handshake is checked.
    task automatic do_fetch(input int waits, input logic irw, input logic [31:0] data,
                            input logic with_pcw, input logic [31:0] jump_to, input logic bad_pcw);
        if (with_pcw) begin
            PCWrite = 1; PCSrc = 2'd3; reg_target = jump_to;
            m_pc = jump_to;
        end
        fetch_start = 1;
        tick;
        fetch_start = 0;
        clear_ctl;
        for (int i = 0; i < waits; i++) begin
            check("wait_req", {31'b0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, m_pc);
            check("wait_done", {31'b0, fetch_done}, 32'd0);
            check("wait_ir", ir, m_ir);
            if (bad_pcw && i == 0) begin
                PCWrite = 1; PCSrc = 2'($urandom_range(0, 3));
                branch_target = $urandom; reg_target = $urandom;
                m_err = 1'b1;
            end
            tick;
            clear_ctl;
        end
        check("ack_req", {31'b0, imem_req}, 32'd1);
        check("ack_addr", imem_addr, m_pc);
        check("ack_busy", {31'b0, fetch_busy}, 32'd1);
        imem_ack = 1; imem_rdata = data; IRWrite = irw;
        if (irw) m_ir = data;
        m_cnt = m_cnt + 32'd1;
        tick;
        imem_ack = 0; IRWrite = 0; imem_rdata = $urandom;
        check("done_pulse", {31'b0, fetch_done}, 32'd1);
        check("done_busy", {31'b0, fetch_busy}, 32'd1);
        check("done_req", {31'b0, imem_req}, 32'd0);
        check("done_ir", ir, m_ir);
        check("done_opcode", {26'b0, opcode}, {26'b0, m_ir[31:26]});
        check("done_count", fetch_count, m_cnt);
        tick;
        check("idle_done", {31'b0, fetch_done}, 32'd0);
        check("idle_busy", {31'b0, fetch_busy}, 32'd0);
        check("fetch_pc", pc, m_pc);
        check("err_flag", {31'b0, pc_update_err}, {31'b0, m_err});
    endtask

    task automatic stray_ack;
        imem_ack = 1; imem_rdata = $urandom; IRWrite = 1;
        tick;
        imem_ack = 0; IRWrite = 0;
        check("stray_ir", ir, m_ir);
        check("stray_count", fetch_count, m_cnt);
        check("stray_busy", {31'b0, fetch_busy}, 32'd0);
    endtask

    initial begin
        rst = 1; fetch_start = 0; IRWrite = 0; imem_ack = 0; imem_rdata = 0;
        branch_target = 0; reg_target = 0;
        clear_ctl;
        model_reset;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        check("rst_err", {31'b0, pc_update_err}, 32'd0);

        // Zero-wait fetch of a known word
        do_fetch(0, 1'b1, 32'h8C22_0004, 1'b0, 32'h0, 1'b0);
        check("first_opcode", {26'b0, opcode}, 32'h23);
        // Three wait states, then a fetch without IR load
        do_fetch(3, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
        do_fetch(1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);

        // Next-pc selection in IDLE
        pc_update(1, 0, 0, 0, 2'd3, 32'h0, 32'd5);
        pc_update(1, 0, 0, 0, 2'd0, 32'h0, 32'h0);
        check("pc_seq6", pc, 32'd6);
        pc_update(0, 1, 1, 0, 2'd1, 32'd20, 32'h0);
        check("beq_not_taken", pc, 32'd6);
        pc_update(0, 1, 1, 1, 2'd1, 32'd20, 32'h0);
        check("beq_taken", pc, 32'd20);
        pc_update(0, 1, 0, 0, 2'd1, 32'd33, 32'h0);
        check("bne_taken", pc, 32'd33);
        pc_update(0, 1, 0, 1, 2'd1, 32'd77, 32'h0);
        check("bne_not_taken", pc, 32'd33);

        do_fetch(0, 1'b1, 32'h0800_0010, 1'b0, 32'h0, 1'b0);
        pc_update(1, 0, 0, 0, 2'd3, 32'h0, 32'hFC00_0003);
        pc_update(1, 0, 0, 0, 2'd2, 32'h0, 32'h0);
        check("jump_concat", pc, 32'hFC00_0010);
        pc_update(1, 0, 0, 0, 2'd3, 32'h0, 32'hFFFF_FFFF);
        pc_update(1, 0, 0, 0, 2'd0, 32'h0, 32'h0);
        check("pc_wrap", pc, 32'h0);

        // pcw together with fetch_start: request goes to the new pc
        do_fetch(0, 1'b1, 32'hAAAA_0001, 1'b1, 32'd40, 1'b0);
        check("jump_fetch_pc", pc, 32'd40);
        // pcw while busy: pc held, sticky error
        do_fetch(2, 1'b1, 32'h5555_0002, 1'b0, 32'h0, 1'b1);
        stray_ack;

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0, 1: pc_update(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                2'($urandom_range(0, 3)), $urandom, $urandom);
                2:    do_fetch($urandom_range(0, 4), 1'($urandom), $urandom, 1'b0, 32'h0,
                               ($urandom_range(0, 9) == 0));
                3:    do_fetch($urandom_range(0, 2), 1'b1, $urandom, 1'b1, $urandom, 1'b0);
                default: stray_ack;
            endcase
        end
        check("err_sticky", {31'b0, pc_update_err}, 32'd1);

        // Reset in the middle of a request
        pc_update(1, 0, 0, 0, 2'd3, 32'h0, 32'h0000_0100);
        fetch_start = 1;
        tick;
        fetch_start = 0;
        check("pre_rst_req", {31'b0, imem_req}, 32'd1);
        #2 rst = 1;
        model_reset;
        #1;
        check("async_rst_req", {31'b0, imem_req}, 32'd0);
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_err", {31'b0, pc_update_err}, 32'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        imem_ack = 1; imem_rdata = 32'hCAFE_F00D; IRWrite = 1;
        tick;
        imem_ack = 0; IRWrite = 0;
        check("post_rst_ir", ir, 32'h0);
        check("post_rst_count", fetch_count, 32'h0);
        check("post_rst_done", {31'b0, fetch_done}, 32'd0);
        check("post_rst_req", {31'b0, imem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end for the multicycle CPU.
- Owns the program counter and instruction register, and runs the instruction-memory request/acknowledge handshake (wait states allowed).
- Computes the next PC from the controller's PCWrite/PCWriteCond/BEQ/PCSrc and the datapath's zero flag.
- Sits directly upstream of the datapath and controller: supplies pc, ir and the opcode, and signals fetch completion so the controller leaves its fetch state.

Parameters:
- ADDR_W, 32, width of pc and memory address.
- RESET_PC, 32'h00000000, pc value after reset.
- PC_INC, 1, sequential increment (IMem is word-addressed).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_start  in  1  controller request to fetch at the current pc; sampled only in IDLE.
- IRWrite  in  1  enables the IR load when the memory acknowledges.
- PCWrite  in  1  unconditional pc update.
- PCWriteCond  in  1  conditional pc update (branch).
- BEQ  in  1  branch sense: 1 = take branch on zero=1; 0 = take branch on zero=0.
- zero  in  1  ALU zero flag.
- PCSrc  in  2  next-pc select.
- branch_target  in  ADDR_W  branch target from the ALU output register.
- reg_target  in  ADDR_W  register-indirect jump target.
- imem_req  out  1  memory request.
- imem_addr  out  ADDR_W  request address.
- imem_ack  in  1  one-cycle acknowledge; imem_rdata is valid in that cycle.
- imem_rdata  in  32  instruction word.
- pc  out  ADDR_W  current program counter.
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26], combinational.
- fetch_busy  out  1  high in REQ and DONE.
- fetch_done  out  1  one-cycle pulse in DONE.
- fetch_count  out  32  count of completed fetches; wraps.
- pc_update_err  out  1  sticky flag: pc update requested while busy.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, ir=0, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, fetch_done=0, fetch_count=0, pc_update_err=0.
- States:
  - IDLE: fetch_start=1 -> REQ.
  - REQ: imem_req=1 and imem_addr=pc, held stable until ack. imem_ack=1 -> DONE; otherwise stay in REQ (unbounded wait).
  - DONE: fetch_done=1 for exactly one cycle -> IDLE. fetch_start is ignored here.
- Fetch latency: fetch_start at edge N -> req high from cycle N+1. With ack in the first REQ cycle, fetch_done is high in cycle N+2 and IDLE is re-entered at edge N+3. Each wait cycle adds one.
- On the ack edge:
  - If IRWrite=1: ir<=imem_rdata. If IRWrite=0: ir is held, but the fetch still completes.
  - fetch_count<=fetch_count+1, modulo 2^32.
- pc write enable: pcw = PCWrite | (PCWriteCond & (BEQ ? zero : ~zero)).
- Next pc by PCSrc:
  - 0: pc+PC_INC, modulo 2^ADDR_W (wraps).
  - 1: branch_target.
  - 2: {pc[ADDR_W-1:26], ir[25:0]}.
  - 3: reg_target.
- pcw is honoured only in IDLE; pc is loaded at that edge.
  - pcw in REQ or DONE: pc is unchanged (the request address must not move) and pc_update_err is set to 1. It clears only on reset.
- Simultaneous pcw and fetch_start in IDLE: pc loads the new value on the same edge the FSM enters REQ, so the request uses the updated pc.
- pc is never modified by the fetch itself; sequencing is the controller's job via PCSrc=0.
- Reset during REQ: imem_req drops asynchronously and a subsequent stray ack is ignored (state is IDLE).
- imem_ack outside REQ: ignored; no state, ir or counter change.

Test Plan:
- Reset, then fetch_start for 1 cycle, ack on the 1st REQ cycle with rdata=32'h8C220004, IRWrite=1 -> imem_addr=0; ir=8C220004; opcode=6'h23; fetch_done is a single pulse 2 cycles after start; fetch_count=1.
- Ack delayed 3 cycles -> imem_req high 4 cycles with imem_addr stable; fetch_done 3 cycles later than the zero-wait case; ir updates only on the ack edge.
- In IDLE with pc=5: PCWrite=1, PCSrc=0 -> pc=6. Then PCWriteCond=1, BEQ=1, zero=0, PCSrc=1, branch_target=20 -> pc stays 6. Same with zero=1 -> pc=20. BEQ=0, zero=0 -> taken.
- ir=32'h08000010, pc=32'hFC000003, PCSrc=2, PCWrite=1 -> pc=32'hFC000010. pc=32'hFFFFFFFF, PCSrc=0 -> pc=0 (wrap).
- PCWrite=1 during REQ -> pc and imem_addr unchanged, pc_update_err=1 and stays set. PCWrite with fetch_start in IDLE, reg_target=40, PCSrc=3 -> first request address=40.
- rst asserted mid-REQ -> imem_req=0 immediately, pc=RESET_PC. Ack one cycle after rst release -> ignored; ir=0, fetch_count=0.
